// File: rtl/lsm_sequencer.sv
// Load/Store Multiple sequencer: latches an LDM/STM register list, computes
// start and writeback addresses for IA/IB/DA/DB, then walks the list R0..R15
// issuing one memory request per selected register at ascending addresses.
module lsm_sequencer #(
  parameter int AW         = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic          CLK,
  input  logic          CLR,
  input  logic          LSM_START,
  input  logic          IR_23,
  input  logic          IR_24,
  input  logic          IR_20,
  input  logic [15:0]   REG_LIST,
  input  logic [AW-1:0] BASE_ADDR,
  input  logic          MEM_DONE,
  output logic          LSM_BUSY,
  output logic          LSM_REQ,
  output logic          LSM_RW,
  output logic [3:0]    LSM_REG,
  output logic [AW-1:0] LSM_ADDR,
  output logic [AW-1:0] LSM_WB_ADDR,
  output logic [4:0]    LSM_COUNT,
  output logic          LSM_DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_CHECK,
    S_XFER,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [15:0]   list_q;
  logic [AW-1:0] base_q;
  logic [AW-1:0] cur_addr;
  logic          u_q;
  logic          p_q;
  logic [3:0]    ptr;
  logic [4:0]    pop;
  logic [AW-1:0] span;
  logic [AW-1:0] step;

  assign step = AW'(WORD_BYTES);
  assign span = AW'(pop) * step;

  // Request, busy and done decode straight from state so an asynchronous
  // reset removes them in the same instant.
  assign LSM_REQ  = (state == S_XFER);
  assign LSM_BUSY = (state != S_IDLE);
  assign LSM_DONE = (state == S_DONE);

  // Number of selected registers in the latched list.
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      pop = pop + 5'(list_q[i]);
    end
  end

  // State register.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (LSM_START) state_nxt = S_COUNT;
      S_COUNT: state_nxt = (pop == 5'd0) ? S_DONE : S_CHECK;
      S_CHECK: begin
        if (list_q[ptr])       state_nxt = S_XFER;
        else if (ptr == 4'hF)  state_nxt = S_DONE;
      end
      S_XFER: begin
        if (MEM_DONE) state_nxt = (ptr == 4'hF) ? S_DONE : S_CHECK;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Operand latching, address computation and list pointer.
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      list_q      <= '0;
      base_q      <= '0;
      cur_addr    <= '0;
      u_q         <= 1'b0;
      p_q         <= 1'b0;
      ptr         <= '0;
      LSM_RW      <= 1'b0;
      LSM_REG     <= '0;
      LSM_ADDR    <= '0;
      LSM_WB_ADDR <= '0;
      LSM_COUNT   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (LSM_START) begin
            list_q <= REG_LIST;
            base_q <= BASE_ADDR;
            u_q    <= IR_23;
            p_q    <= IR_24;
            LSM_RW <= IR_20;
            ptr    <= '0;
          end
        end
        S_COUNT: begin
          LSM_COUNT   <= pop;
          LSM_WB_ADDR <= u_q ? (base_q + span) : (base_q - span);
          // Decrementing modes still transfer upward, so they start at the
          // lowest address of the block.
          case ({u_q, p_q})
            2'b10:   cur_addr <= base_q;
            2'b11:   cur_addr <= base_q + step;
            2'b00:   cur_addr <= base_q - span + step;
            default: cur_addr <= base_q - span;
          endcase
        end
        S_CHECK: begin
          if (list_q[ptr]) begin
            LSM_REG  <= ptr;
            LSM_ADDR <= cur_addr;
          end else if (ptr != 4'hF) begin
            ptr <= ptr + 4'd1;
          end
        end
        S_XFER: begin
          if (MEM_DONE) begin
            cur_addr <= cur_addr + step;
            if (ptr != 4'hF) ptr <= ptr + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Directed bench for lsm_sequencer: acts as the control unit and memory,
// checking every request, address, count and writeback against hand values.
module tb_lsm_sequencer;

  logic        CLK;
  logic        CLR;
  logic        LSM_START;
  logic        IR_23;
  logic        IR_24;
  logic        IR_20;
  logic [15:0] REG_LIST;
  logic [31:0] BASE_ADDR;
  logic        MEM_DONE;
  logic        LSM_BUSY;
  logic        LSM_REQ;
  logic        LSM_RW;
  logic [3:0]  LSM_REG;
  logic [31:0] LSM_ADDR;
  logic [31:0] LSM_WB_ADDR;
  logic [4:0]  LSM_COUNT;
  logic        LSM_DONE;

  int checks;
  int failures;

  lsm_sequencer #(.AW(32), .WORD_BYTES(4)) dut (
    .CLK         (CLK),
    .CLR         (CLR),
    .LSM_START   (LSM_START),
    .IR_23       (IR_23),
    .IR_24       (IR_24),
    .IR_20       (IR_20),
    .REG_LIST    (REG_LIST),
    .BASE_ADDR   (BASE_ADDR),
    .MEM_DONE    (MEM_DONE),
    .LSM_BUSY    (LSM_BUSY),
    .LSM_REQ     (LSM_REQ),
    .LSM_RW      (LSM_RW),
    .LSM_REG     (LSM_REG),
    .LSM_ADDR    (LSM_ADDR),
    .LSM_WB_ADDR (LSM_WB_ADDR),
    .LSM_COUNT   (LSM_COUNT),
    .LSM_DONE    (LSM_DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Runs one LDM/STM. Inputs are driven and outputs sampled on the falling edge.
  // exp_first: address of the first transfer; exp_lat: cycle of first REQ
  // (cycle 1 = first cycle after START); glitch pulses START mid-transfer.
  task automatic run_op(input logic u, input logic p, input logic l,
                        input logic [15:0] lst, input logic [31:0] base,
                        input int delay, input int exp_n,
                        input logic [31:0] exp_first, input logic [31:0] exp_wb,
                        input int exp_lat, input bit glitch);
    int          cyc;
    int          exp_reg;
    int          wait_cnt;
    int          nreq;
    int          first_cyc;
    bit          done_seen;
    logic [31:0] exp_addr;
    @(negedge CLK);
    IR_23 = u; IR_24 = p; IR_20 = l; REG_LIST = lst; BASE_ADDR = base;
    LSM_START = 1'b1;
    @(negedge CLK);
    LSM_START = 1'b0;
    REG_LIST  = 16'hFFFF;
    BASE_ADDR = 32'hDEAD_BEE0;
    cyc = 1; exp_reg = 0; wait_cnt = 0; nreq = 0; first_cyc = -1; done_seen = 0;
    exp_addr = exp_first;
    check("busy_after_start", {31'd0, LSM_BUSY}, 32'd1);
    while (!done_seen && cyc < 400) begin
      MEM_DONE  = 1'b0;
      LSM_START = 1'b0;
      if (LSM_REQ) begin
        if (first_cyc < 0) begin
          first_cyc = cyc;
          check("first_req_latency", first_cyc, exp_lat);
        end
        if (wait_cnt == 0)
          while (exp_reg < 16 && !lst[exp_reg]) exp_reg++;
        if (exp_reg > 15) begin
          check("extra_req", 32'd1, 32'd0);
          wait_cnt = 0;
        end else begin
          check(wait_cnt == 0 ? "req_reg" : "hold_reg", {28'd0, LSM_REG}, exp_reg);
          check(wait_cnt == 0 ? "req_addr" : "hold_addr", LSM_ADDR, exp_addr);
          check("req_rw", {31'd0, LSM_RW}, {31'd0, l});
          if (glitch && wait_cnt == 1) begin
            LSM_START = 1'b1;
            REG_LIST  = 16'h0001;
          end
          if (wait_cnt == delay) begin
            MEM_DONE = 1'b1;
            wait_cnt = 0;
            exp_reg++;
            exp_addr += 32'd4;
            nreq++;
          end else begin
            wait_cnt++;
          end
        end
      end
      if (LSM_DONE) begin
        done_seen = 1;
        check("done_count", {27'd0, LSM_COUNT}, exp_n);
        check("done_wb_addr", LSM_WB_ADDR, exp_wb);
        check("done_nreq", nreq, exp_n);
        check("done_busy", {31'd0, LSM_BUSY}, 32'd1);
        check("done_no_req", {31'd0, LSM_REQ}, 32'd0);
        if (exp_n == 0) check("empty_done_cycle", cyc, 2);
      end
      @(negedge CLK);
      cyc++;
    end
    MEM_DONE  = 1'b0;
    LSM_START = 1'b0;
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    check("done_one_pulse", {31'd0, LSM_DONE}, 32'd0);
    check("idle_busy", {31'd0, LSM_BUSY}, 32'd0);
    check("wb_hold", LSM_WB_ADDR, exp_wb);
  endtask

  initial begin
    int guard;
    checks = 0; failures = 0;
    CLR = 1'b0; LSM_START = 1'b0; IR_23 = 1'b0; IR_24 = 1'b0; IR_20 = 1'b0;
    REG_LIST = '0; BASE_ADDR = '0; MEM_DONE = 1'b0;
    repeat (2) @(negedge CLK);
    check("rst_busy",  {31'd0, LSM_BUSY}, 32'd0);
    check("rst_req",   {31'd0, LSM_REQ}, 32'd0);
    check("rst_rw",    {31'd0, LSM_RW}, 32'd0);
    check("rst_reg",   {28'd0, LSM_REG}, 32'd0);
    check("rst_addr",  LSM_ADDR, 32'd0);
    check("rst_wb",    LSM_WB_ADDR, 32'd0);
    check("rst_count", {27'd0, LSM_COUNT}, 32'd0);
    check("rst_done",  {31'd0, LSM_DONE}, 32'd0);
    CLR = 1'b1;
    @(negedge CLK);

    // STMIA base 0x1000, R0,R2
    run_op(1'b1, 1'b0, 1'b0, 16'h0005, 32'h0000_1000, 0, 2, 32'h0000_1000, 32'h0000_1008, 3, 0);
    // LDMDB base 0x2000, R0,R15
    run_op(1'b0, 1'b1, 1'b1, 16'h8001, 32'h0000_2000, 0, 2, 32'h0000_1FF8, 32'h0000_1FF8, 3, 0);
    // LDMDA base 0x2000, R0,R15
    run_op(1'b0, 1'b0, 1'b1, 16'h8001, 32'h0000_2000, 0, 2, 32'h0000_1FFC, 32'h0000_1FF8, 3, 0);
    // LDMIB base 0, all registers
    run_op(1'b1, 1'b1, 1'b1, 16'hFFFF, 32'h0000_0000, 0, 16, 32'h0000_0004, 32'h0000_0040, 3, 0);
    // empty list
    run_op(1'b1, 1'b0, 1'b1, 16'h0000, 32'h0000_3000, 0, 0, 32'h0000_3000, 32'h0000_3000, 0, 0);
    // STMIA with 5 wait states, R4,R8: first REQ after 4 skipped registers
    run_op(1'b1, 1'b0, 1'b0, 16'h0110, 32'h0000_0500, 5, 2, 32'h0000_0500, 32'h0000_0508, 7, 0);
    // STMDB wrapping below zero
    run_op(1'b0, 1'b1, 1'b0, 16'h0003, 32'h0000_0004, 0, 2, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 3, 0);
    // LDMIA R5,R6 with START pulsed during each transfer
    run_op(1'b1, 1'b0, 1'b1, 16'h0060, 32'h0000_0100, 3, 2, 32'h0000_0100, 32'h0000_0108, 8, 1);

    // Abort in the middle of a transfer.
    @(negedge CLK);
    IR_23 = 1'b1; IR_24 = 1'b0; IR_20 = 1'b1; REG_LIST = 16'h0003; BASE_ADDR = 32'h0000_7000;
    LSM_START = 1'b1;
    @(negedge CLK);
    LSM_START = 1'b0;
    guard = 0;
    while (!LSM_REQ && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check("abort_req_seen", {31'd0, LSM_REQ}, 32'd1);
    CLR = 1'b0;
    #1;
    check("abort_req",   {31'd0, LSM_REQ}, 32'd0);
    check("abort_busy",  {31'd0, LSM_BUSY}, 32'd0);
    check("abort_done",  {31'd0, LSM_DONE}, 32'd0);
    check("abort_count", {27'd0, LSM_COUNT}, 32'd0);
    check("abort_wb",    LSM_WB_ADDR, 32'd0);
    @(negedge CLK);
    CLR = 1'b1;
    @(negedge CLK);
    check("abort_no_done", {31'd0, LSM_DONE}, 32'd0);

    // Full sequence after reset release: STMIB base 0x40, R1,R3
    run_op(1'b1, 1'b1, 1'b0, 16'h000A, 32'h0000_0040, 1, 2, 32'h0000_0044, 32'h0000_0048, 4, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsm_sequencer.md
Name: lsm_sequencer

Overview:
- Sequences a Load/Store Multiple (LDM/STM) transfer once the control unit decodes one.
- Latches the 16-bit register list, counts the set bits and computes the start and writeback addresses for all four addressing modes (IA/IB/DA/DB).
- Scans the list R0→R15 and issues one memory handshake per selected register, lowest register at lowest address.
- Sits between the control unit (start/done), the register file (register number) and the memory interface (request/MOC handshake).

Parameters:
- AW, 32, address width of base, transfer and writeback addresses.
- WORD_BYTES, 4, address step per transferred register.

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- CLR  input  1  asynchronous, active-low reset.
- LSM_START  input  1  one-cycle start pulse from control unit; sampled only in IDLE.
- IR_23  input  1  U bit: 1 = increment, 0 = decrement.
- IR_24  input  1  P bit: 1 = before, 0 = after.
- IR_20  input  1  L bit: 1 = load, 0 = store.
- REG_LIST  input  16  IR[15:0] register list; bit n selects Rn.
- BASE_ADDR  input  AW  base register value Rn.
- MEM_DONE  input  1  memory operation complete (MOC) for the current request.
- LSM_BUSY  output  1  high from the cycle after an accepted START through the DONE state.
- LSM_REQ  output  1  memory request for the current register; held until MEM_DONE.
- LSM_RW  output  1  latched L bit: 1 = read (load), 0 = write (store).
- LSM_REG  output  4  register number being transferred.
- LSM_ADDR  output  AW  memory address for the current transfer.
- LSM_WB_ADDR  output  AW  base writeback value; valid from COUNT exit onward.
- LSM_COUNT  output  5  popcount of the latched list, 0..16.
- LSM_DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset (CLR=0, asynchronous): state=IDLE. All outputs are 0: LSM_BUSY, LSM_REQ, LSM_RW, LSM_REG, LSM_ADDR, LSM_WB_ADDR, LSM_COUNT, LSM_DONE. Latched list and pointer are 0. CLR asserted mid-operation aborts immediately; LSM_REQ drops in the same instant with no completion pulse.
- States: IDLE, COUNT, CHECK, XFER, DONE.
- IDLE:
  - LSM_START=1 → latch REG_LIST, BASE_ADDR, IR_23, IR_24, IR_20, pointer=0 → COUNT.
  - START in any other state is ignored.
- COUNT (1 cycle):
  - LSM_COUNT=popcount(list), n.
  - Start address: IA=base; IB=base+4; DA=base−4n+4; DB=base−4n.
  - LSM_WB_ADDR = U ? base+4n : base−4n.
  - Arithmetic is modulo 2^AW; wrap-around is permitted and not flagged.
  - n=0 → DONE with LSM_WB_ADDR=base; otherwise → CHECK.
- CHECK (one list bit per cycle):
  - list[pointer]=1 → LSM_REG=pointer, LSM_ADDR=current address → XFER.
  - Else if pointer=15 → DONE.
  - Else pointer+1, stay in CHECK.
- XFER:
  - LSM_REQ=1.
  - LSM_REG, LSM_ADDR and LSM_RW are stable until MEM_DONE is sampled high.
  - On MEM_DONE: REQ drops next cycle and current address += WORD_BYTES.
  - If pointer=15 → DONE, else pointer+1 → CHECK.
  - MEM_DONE outside XFER is ignored.
- DONE (1 cycle): LSM_DONE=1, LSM_BUSY=1, LSM_REQ=0 → IDLE. LSM_WB_ADDR and LSM_COUNT hold their values until the next START.
- Transfer order is always ascending register number at ascending address, for every mode.
- Latency: START→first LSM_REQ = 3 cycles plus the number of leading unselected registers. Each transfer costs 1 CHECK cycle plus the MEM_DONE wait.

Test Plan:
- STMIA: base 0x1000, list 0x0005, MEM_DONE one cycle after each REQ → REQ R0@0x1000, then R2@0x1004; LSM_RW=0; LSM_COUNT=2; LSM_WB_ADDR=0x1008; one LSM_DONE pulse.
- LDMDB: base 0x2000, list 0x8001 → R0@0x1FF8, R15@0x1FFC; LSM_RW=1; LSM_WB_ADDR=0x1FF8. Repeat with DA → R0@0x1FFC, R15@0x2000.
- LDMIB: base 0x0, list 0xFFFF → 16 requests R0..R15 at 0x4..0x40; LSM_COUNT=16; LSM_WB_ADDR=0x40; no missing or duplicate REQ.
- Empty list: list 0x0000, base 0x3000 → no LSM_REQ; LSM_DONE exactly 2 cycles after START; LSM_WB_ADDR=0x3000.
- Wait states and wrap: MEM_DONE delayed 5 cycles → REQ/REG/ADDR held constant. DB with base 0x4, list 0x0003 → addresses 0xFFFFFFFC, 0x0, WB 0xFFFFFFFC.
- Robustness:
  - START pulsed during XFER → ignored, sequence unchanged.
  - CLR low mid-XFER → LSM_REQ and LSM_BUSY go to 0 immediately.
  - After CLR release, a new START runs a full sequence normally.
